// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// TX_OUT and busy are registered from the next-state decode so the line never glitches.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  bit_done_s;
  logic                  accept_s;
  logic                  tx_r;
  logic                  tx_s;
  logic                  busy_r;
  logic                  busy_s;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign bit_done_s = (cnt_r == CNT_LAST);
  assign accept_s   = (state_r == IDLE) && data_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_valid) state_s = START;
        else            state_s = IDLE;
      end
      START: begin
        if (bit_done_s) state_s = DATA;
        else            state_s = START;
      end
      DATA: begin
        if (bit_done_s && (idx_r == IDX_LAST)) state_s = par_en_r ? PARITY : STOP;
        else                                   state_s = DATA;
      end
      PARITY: begin
        if (bit_done_s) state_s = STOP;
        else            state_s = PARITY;
      end
      STOP: begin
        if (bit_done_s) state_s = IDLE;
        else            state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Bit-period and data-index counter next values
  always_comb begin
    cnt_s = cnt_r;
    idx_s = idx_r;
    if (state_r == IDLE) begin
      cnt_s = '0;
    end else if (bit_done_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
    if (state_r != DATA) begin
      idx_s = '0;
    end else if (bit_done_s) begin
      idx_s = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      idx_s = idx_r;
    end
  end

  // Counters and frame parameters captured at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      idx_r     <= '0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      idx_r <= idx_s;
      if (accept_s) begin
        data_r    <= P_DATA;
        par_en_r  <= par_en;
        par_typ_r <= par_typ;
      end else begin
        data_r    <= data_r;
        par_en_r  <= par_en_r;
        par_typ_r <= par_typ_r;
      end
    end
  end

  // Output decode from the state being entered, so the register lines up with it
  always_comb begin
    tx_s   = 1'b1;
    busy_s = 1'b0;
    case (state_s)
      IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
      START: begin
        tx_s   = 1'b0;
        busy_s = 1'b1;
      end
      DATA: begin
        tx_s   = data_r[idx_s];
        busy_s = 1'b1;
      end
      PARITY: begin
        tx_s   = parity_bit(data_r, par_typ_r);
        busy_s = 1'b1;
      end
      STOP: begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= busy_s;
    end
  end

  assign TX_OUT = tx_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: one DUT at 4 clocks/bit and one at 1 clock/bit.
// Expected frames are built arithmetically and checked cycle by cycle by a monitor.
`timescale 1ns/1ps
module tb_uart_tx;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
  logic [1:0] dv;
  logic [1:0] tx;
  logic [1:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  frame_t q0[$];
  frame_t q1[$];

  logic   in_frame[2];
  logic   prev_busy[2];
  int     cyc[2];
  int     gap[2];
  logic   b2b[2];
  logic   seen[2];
  frame_t cur[2];

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .P_DATA(p_data), .data_valid(dv[0]),
    .par_en(par_en), .par_typ(par_typ), .TX_OUT(tx[0]), .busy(busy[0])
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .P_DATA(p_data), .data_valid(dv[1]),
    .par_en(par_en), .par_typ(par_typ), .TX_OUT(tx[1]), .busy(busy[1])
  );

  function automatic int cpb(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  // Line image of a frame: position k is the level of the k-th serial bit.
  function automatic frame_t model(input logic [7:0] d, input logic pe, input logic pt);
    frame_t f;
    int     ones;
    int     n;
    int     v;
    f.bits = 16'h0000;
    ones   = 0;
    v      = int'(d);
    for (int i = 0; i < 8; i++) begin
      f.bits[1 + i] = ((v / (1 << i)) % 2) == 1;
      ones += (v / (1 << i)) % 2;
    end
    n = 9;
    if (pe) begin
      f.bits[n] = ((ones % 2) == 1) ^ (pt == 1'b1);
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    f.nbits = 5'(n);
    return f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int g);
    logic b;
    logic t;
    int   idx;
    b = busy[g];
    t = tx[g];
    if (rst == 1'b0) begin
      check($sformatf("dut%0d reset_tx", g), int'(t), 1);
      check($sformatf("dut%0d reset_busy", g), int'(b), 0);
      in_frame[g]  = 1'b0;
      prev_busy[g] = 1'b0;
    end else begin
      if (b && !prev_busy[g]) begin
        if (b2b[g] && seen[g]) check($sformatf("dut%0d b2b_gap", g), gap[g], 1);
        if (((g == 0) ? q0.size() : q1.size()) == 0) begin
          check($sformatf("dut%0d unexpected_frame", g), 1, 0);
          in_frame[g] = 1'b0;
        end else begin
          if (g == 0) cur[g] = q0.pop_front();
          else        cur[g] = q1.pop_front();
          in_frame[g] = 1'b1;
          cyc[g]      = 0;
        end
      end
      if (b && in_frame[g]) begin
        idx = cyc[g] / cpb(g);
        check($sformatf("dut%0d tx_bit c%0d", g, cyc[g]), int'(t),
              (idx < int'(cur[g].nbits)) ? int'(cur[g].bits[idx]) : 1);
        cyc[g]++;
      end
      if (!b && prev_busy[g] && in_frame[g]) begin
        check($sformatf("dut%0d busy_len", g), cyc[g], int'(cur[g].nbits) * cpb(g));
        in_frame[g] = 1'b0;
        gap[g]      = 0;
        seen[g]     = 1'b1;
      end
      if (!b) begin
        check($sformatf("dut%0d idle_tx", g), int'(t), 1);
        gap[g]++;
      end
      prev_busy[g] = b;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    while (busy[g] && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy[g]) check($sformatf("dut%0d idle_timeout", g), int'(busy[g]), 0);
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic pe, input logic pt);
    wait_idle(g);
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    dv[g]   = 1'b1;
    if (g == 0) q0.push_back(model(d, pe, pt));
    else        q1.push_back(model(d, pe, pt));
    @(posedge clk);
    #1;
    dv[g] = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    dv      = 2'b00;
    p_data  = 8'h00;
    par_en  = 1'b0;
    par_typ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_frame[i]  = 1'b0;
      prev_busy[i] = 1'b0;
      cyc[i]       = 0;
      gap[i]       = 0;
      b2b[i]       = 1'b0;
      seen[i]      = 1'b0;
    end
    dv[0] = 1'b1;
    dv[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx0", int'(tx[0]), 1);
    check("reset_busy0", int'(busy[0]), 0);
    check("reset_tx1", int'(tx[1]), 1);
    check("reset_busy1", int'(busy[1]), 0);
    dv  = 2'b00;
    rst = 1'b1;

    send(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b1, 1'b0);
    send(0, 8'hA5, 1'b1, 1'b1);

    // Inputs change and a request pulses mid-frame; neither may affect the line.
    send(0, 8'hA5, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    p_data = 8'hFF;
    par_en = 1'b1;
    dv[0]  = 1'b1;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    wait_idle(0);
    repeat (5) @(posedge clk);

    // Request held high: three frames with a single idle cycle between them.
    wait_idle(0);
    seen[0] = 1'b0;
    b2b[0]  = 1'b1;
    p_data  = 8'h01;
    par_en  = 1'b0;
    par_typ = 1'b0;
    dv[0]   = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(model(8'h01, 1'b0, 1'b0));
    repeat (83) @(posedge clk);
    #1;
    dv[0] = 1'b0;
    wait_idle(0);
    b2b[0] = 1'b0;

    // Reset during data bit 3, then a clean frame.
    send(0, 8'h5A, 1'b1, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_tx", int'(tx[0]), 1);
    check("abort_busy", int'(busy[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_idle", int'(busy[0]), 0);
    send(0, 8'h3C, 1'b0, 1'b0);

    send(1, 8'h80, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      send(0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 15; i++) begin
      send(1, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(posedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: number of data bits per frame (>=1).
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16: clk cycles per serial bit (>=1).
REQ-003 SHALL have clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have data_valid  input  1  request to start a frame with P_DATA.
REQ-007 SHALL have par_en  input  1  1 = insert parity bit after data.
REQ-008 SHALL have par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL, in IDLE, drive TX_OUT=1 and busy=0.
REQ-013 SHALL accept a request only when data_valid=1 at a rising edge in IDLE; data_valid while busy=1 is ignored, not queued.
REQ-014 SHALL on acceptance latch P_DATA, par_en, par_typ into internal registers; later input changes do not affect the frame.
REQ-015 SHALL enter START the cycle after acceptance: TX_OUT=0, busy=1 from that cycle on.
REQ-016 SHALL hold every serial bit (start, each data, parity, stop) for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that resets at every bit boundary.
REQ-017 SHALL send data bits LSB first (bit 0 first, bit DATA_WIDTH-1 last) in DATA, using a data-bit index counter 0..DATA_WIDTH-1.
REQ-018 SHALL after the last data bit go to PARITY if latched par_en=1, else directly to STOP.
REQ-019 SHALL in PARITY drive XOR of latched data bits when par_typ=0, its inverse when par_typ=1.
REQ-020 SHALL in STOP drive TX_OUT=1, then return to IDLE; busy falls to 0 on the cycle IDLE is entered.
REQ-021 SHALL keep busy=1 for exactly (2+DATA_WIDTH+par_en)*CLKS_PER_BIT cycles per frame.
REQ-022 SHALL accept a new data_valid on the first IDLE cycle after STOP; minimum inter-frame gap is one IDLE cycle.
REQ-023 SHALL register TX_OUT (no combinational path from inputs to TX_OUT).
REQ-024 SHALL, with CLKS_PER_BIT=1, send one bit per cycle with identical ordering.

Reset
REQ-025 SHALL on rst=0 immediately (asynchronously) force state=IDLE, TX_OUT=1, busy=0, all counters and latched data to 0.
REQ-026 SHALL, on rst asserted mid-frame, abort the frame; after release stay IDLE until a new data_valid.
REQ-027 SHALL ignore data_valid while rst=0.

Verification
REQ-028 SHALL check basic frame: DATA_WIDTH=8, CLKS_PER_BIT=4, par_en=0, P_DATA=0xA5 -> TX_OUT 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; busy high 40 cycles.
REQ-029 SHALL check parity: P_DATA=0xA5, par_en=1, par_typ=0 -> parity bit 0; par_typ=1 -> parity bit 1; busy high 44 cycles.
REQ-030 SHALL check input latching/ignore: change P_DATA to 0xFF and pulse data_valid mid-frame -> frame still 0xA5, no second frame starts.
REQ-031 SHALL check back-to-back: data_valid held high continuously with 0x01 -> frames separated by exactly one IDLE cycle of TX_OUT=1, busy=0.
REQ-032 SHALL check reset mid-frame: assert rst during data bit 3 -> TX_OUT=1, busy=0 same cycle; after release and new data_valid with 0x3C, full correct frame sent.
REQ-033 SHALL check CLKS_PER_BIT=1, P_DATA=0x80, par_en=1, par_typ=1 -> TX_OUT 0,0,0,0,0,0,0,0,1,0,1 over 11 cycles.
